csr_access_unit: RTL and testbench

//  Initiator side of the CSR register-file port: executes Zicsr instructions (CSRRW/S/C, CSRRWI/SI/CI).

---
 rtl/csr_access_unit_pkg.sv | 30 +++
 rtl/csr_access_unit_alu.sv | 23 ++
 rtl/csr_access_unit.sv | 136 +++++++++++++
 tb/tb_csr_access_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - shared constants, state encoding and decode helpers for the CSR access unit
package csr_access_unit_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_CSR_AW = 12;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // Top two address bits of a read-only CSR
    localparam logic [1:0] RO_CSR_PREFIX = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Set/clear forms with rs1/zimm of zero are pure reads and never write the CSR
    function automatic logic write_intended(input logic [2:0] funct3, input logic [4:0] rs1_idx);
        return (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
    endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// rtl/csr_access_unit_alu.sv - combinational read-modify-write datapath for Zicsr operations
module csr_alu
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] new_val
);

    always_comb begin
        new_val = old;
        case (funct3)
            F3_CSRRW, F3_CSRRWI: new_val = operand;
            F3_CSRRS, F3_CSRRSI: new_val = old | operand;
            F3_CSRRC, F3_CSRRCI: new_val = old & ~operand;
            default:             new_val = old;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - EX-stage initiator executing Zicsr instructions against the CSR register-file port
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int CSR_AW = DEF_CSR_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [CSR_AW-1:0] csr_addr_i,
    input  logic [4:0]        rs1_idx_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [4:0]        rd_idx_i,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic              csr_we_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    input  logic              flush_i,
    output logic              done_o,
    output logic              illegal_o,
    output logic              rd_we_o,
    output logic [4:0]        rd_idx_o,
    output logic [XLEN-1:0]   rd_wdata_o,
    output logic              retire_o
);

    state_e            state_q, state_d;
    logic [2:0]        funct3_q;
    logic [CSR_AW-1:0] csr_addr_q;
    logic [XLEN-1:0]   operand_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   new_val;
    logic [4:0]        rd_idx_q;
    logic              write_q;
    logic              illegal_q;

    logic              accept;
    logic              req_write;
    logic              req_illegal;
    logic [XLEN-1:0]   req_operand;

    // Ready is held low while reset is asserted, not just after it releases
    assign req_ready_o = (state_q == ST_IDLE) && !rst;
    assign accept      = req_valid_i && req_ready_o && !flush_i;
    assign req_write   = write_intended(funct3_i, rs1_idx_i);
    assign req_illegal = (funct3_i[1:0] == 2'b00) ||
                         (req_write && (csr_addr_i[CSR_AW-1 -: 2] == RO_CSR_PREFIX));
    assign req_operand = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3  (funct3_q),
        .old     (old_q),
        .operand (operand_q),
        .new_val (new_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            funct3_q   <= '0;
            csr_addr_q <= '0;
            operand_q  <= '0;
            old_q      <= '0;
            rd_idx_q   <= '0;
            write_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                funct3_q  <= funct3_i;
                operand_q <= req_operand;
                rd_idx_q  <= rd_idx_i;
                write_q   <= req_write;
                illegal_q <= req_illegal;
                // Illegal ops never touch the port, so the port keeps its last address
                if (!req_illegal) begin
                    csr_addr_q <= csr_addr_i;
                end
            end
            if (state_q == ST_CAP) begin
                old_q <= csr_rdata_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        csr_addr_o  = csr_addr_q;
        csr_we_o    = 1'b0;
        csr_wdata_o = '0;
        done_o      = 1'b0;
        illegal_o   = 1'b0;
        rd_we_o     = 1'b0;
        rd_idx_o    = '0;
        rd_wdata_o  = '0;
        retire_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = req_illegal ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                state_d = flush_i ? ST_IDLE : ST_CAP;
            end
            ST_CAP: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = write_q ? ST_WR : ST_DONE;
                end
            end
            ST_WR: begin
                csr_we_o    = 1'b1;
                csr_wdata_o = new_val;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done_o    = 1'b1;
                illegal_o = illegal_q;
                rd_idx_o  = rd_idx_q;
                if (!illegal_q) begin
                    retire_o   = 1'b1;
                    rd_we_o    = (rd_idx_q != 5'd0);
                    rd_wdata_o = old_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - self-checking bench for csr_access_unit
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  funct3_i;
    logic [11:0] csr_addr_i;
    logic [4:0]  rs1_idx_i;
    logic [31:0] rs1_data_i;
    logic [4:0]  rd_idx_i;
    logic [11:0] csr_addr_o;
    logic        csr_we_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_rdata_i;
    logic        flush_i;
    logic        done_o;
    logic        illegal_o;
    logic        rd_we_o;
    logic [4:0]  rd_idx_o;
    logic [31:0] rd_wdata_o;
    logic        retire_o;

    always #5 clk = ~clk;

    csr_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .funct3_i    (funct3_i),
        .csr_addr_i  (csr_addr_i),
        .rs1_idx_i   (rs1_idx_i),
        .rs1_data_i  (rs1_data_i),
        .rd_idx_i    (rd_idx_i),
        .csr_addr_o  (csr_addr_o),
        .csr_we_o    (csr_we_o),
        .csr_wdata_o (csr_wdata_o),
        .csr_rdata_i (csr_rdata_i),
        .flush_i     (flush_i),
        .done_o      (done_o),
        .illegal_o   (illegal_o),
        .rd_we_o     (rd_we_o),
        .rd_idx_o    (rd_idx_o),
        .rd_wdata_o  (rd_wdata_o),
        .retire_o    (retire_o)
    );

    // CSR file model: synchronous write, read data one cycle after the address
    logic [31:0] csr_mem [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    always @(posedge clk) begin
        if (csr_we_o) csr_mem[csr_addr_o] <= csr_wdata_o;
        else if (pre_en) csr_mem[pre_addr] <= pre_data;
        csr_rdata_i <= csr_mem[csr_addr_o];
    end

    int retire_cnt = 0;
    always @(negedge clk) if (retire_o) retire_cnt <= retire_cnt + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Issues one request and observes up to 8 cycles; cyc=0 means no done_o seen
    task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] ri,
                          input logic [31:0] d, input logic [4:0] rdi, input int flush_at,
                          output int cyc, output int nwe, output logic [31:0] wd,
                          output logic [11:0] wa, output logic ill, output logic rdwe,
                          output logic [31:0] rdw, output logic [4:0] rdidx, output logic ret);
        int w;
        cyc = 0; nwe = 0; wd = '0; wa = '0; ill = 0; rdwe = 0; rdw = '0; rdidx = '0; ret = 0;
        @(negedge clk);
        funct3_i = f3; csr_addr_i = a; rs1_idx_i = ri; rs1_data_i = d; rd_idx_i = rdi;
        req_valid_i = 1'b1;
        w = 0;
        while (!req_ready_o && w < 20) begin @(negedge clk); w++; end
        if (!req_ready_o) check("ready_timeout", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        funct3_i = 3'($urandom); csr_addr_i = 12'($urandom); rs1_idx_i = 5'($urandom);
        rs1_data_i = $urandom; rd_idx_i = 5'($urandom);
        for (int n = 1; n <= 8; n++) begin
            flush_i = (n == flush_at);
            @(negedge clk);
            if (csr_we_o) begin nwe++; wd = csr_wdata_o; wa = csr_addr_o; end
            if (done_o) begin
                cyc = n; ill = illegal_o; rdwe = rd_we_o; rdw = rd_wdata_o;
                rdidx = rd_idx_o; ret = retire_o;
                break;
            end
            @(posedge clk); #1;
        end
        flush_i = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  ri;
        logic [31:0] rs1;
        logic [4:0]  rd;
        logic [31:0] init;
        int          cyc;
        int          nwe;
        logic [31:0] wd;
        logic        ill;
        logic        rdwe;
        logic [31:0] rdw;
        logic        ret;
        logic [31:0] fin;
    } vec_t;

    vec_t vt [14];

    initial begin
        int cyc, nwe;
        logic [31:0] wd, rdw;
        logic [11:0] wa;
        logic ill, rdwe, ret;
        logic [4:0] rdidx;

        vt[0]  = '{3'b001, 12'h340, 5'd6,  32'hDEADBEEF, 5'd5,  32'h11,       4, 1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h11,       1'b1, 32'hDEADBEEF};
        vt[1]  = '{3'b010, 12'h300, 5'd0,  32'h0000FFFF, 5'd0,  32'h1800,     3, 0, 32'h0,        1'b0, 1'b0, 32'h1800,     1'b1, 32'h1800};
        vt[2]  = '{3'b111, 12'h304, 5'd5,  32'hFFFFFFFF, 5'd3,  32'hF,        4, 1, 32'hA,        1'b0, 1'b1, 32'hF,        1'b1, 32'hA};
        vt[3]  = '{3'b001, 12'hC00, 5'd1,  32'h12345678, 5'd4,  32'h99,       1, 0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h99};
        vt[4]  = '{3'b100, 12'h340, 5'd1,  32'h0,        5'd5,  32'h22,       1, 0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h22};
        vt[5]  = '{3'b000, 12'h340, 5'd0,  32'h0,        5'd5,  32'h22,       1, 0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h22};
        vt[6]  = '{3'b010, 12'h341, 5'd2,  32'hF0,       5'd7,  32'hF,        4, 1, 32'hFF,       1'b0, 1'b1, 32'hF,        1'b1, 32'hFF};
        vt[7]  = '{3'b110, 12'h305, 5'h10, 32'hFFFFFFFF, 5'd1,  32'h3,        4, 1, 32'h13,       1'b0, 1'b1, 32'h3,        1'b1, 32'h13};
        vt[8]  = '{3'b011, 12'h342, 5'd9,  32'h0000FFFF, 5'd2,  32'h12345678, 4, 1, 32'h12340000, 1'b0, 1'b1, 32'h12345678, 1'b1, 32'h12340000};
        vt[9]  = '{3'b010, 12'hC00, 5'd0,  32'hFFFFFFFF, 5'd4,  32'h77,       3, 0, 32'h0,        1'b0, 1'b1, 32'h77,       1'b1, 32'h77};
        vt[10] = '{3'b101, 12'h340, 5'd0,  32'hFFFFFFFF, 5'd0,  32'hAB,       4, 1, 32'h0,        1'b0, 1'b0, 32'hAB,       1'b1, 32'h0};
        vt[11] = '{3'b111, 12'hC01, 5'd0,  32'hFFFFFFFF, 5'd9,  32'h55,       3, 0, 32'h0,        1'b0, 1'b1, 32'h55,       1'b1, 32'h55};
        vt[12] = '{3'b110, 12'hC02, 5'd1,  32'h0,        5'd9,  32'h66,       1, 0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h66};
        vt[13] = '{3'b001, 12'h7FF, 5'd3,  32'h1,        5'd31, 32'h0,        4, 1, 32'h1,        1'b0, 1'b1, 32'h0,        1'b1, 32'h1};

        rst = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; funct3_i = '0; csr_addr_i = '0;
        rs1_idx_i = '0; rs1_data_i = '0; rd_idx_i = '0;

        repeat (2) @(negedge clk);
        check("rst_ready",   32'(req_ready_o), 32'd0);
        check("rst_we",      32'(csr_we_o),    32'd0);
        check("rst_addr",    32'(csr_addr_o),  32'd0);
        check("rst_done",    32'(done_o),      32'd0);
        check("rst_rdwdata", rd_wdata_o,       32'd0);
        check("rst_retire",  32'(retire_o),    32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready_o), 32'd1);

        for (int i = 0; i < 14; i++) begin
            preload(vt[i].addr, vt[i].init);
            run_op(vt[i].f3, vt[i].addr, vt[i].ri, vt[i].rs1, vt[i].rd, 0,
                   cyc, nwe, wd, wa, ill, rdwe, rdw, rdidx, ret);
            check($sformatf("v%0d_cyc", i),    32'(cyc),  32'(vt[i].cyc));
            check($sformatf("v%0d_nwe", i),    32'(nwe),  32'(vt[i].nwe));
            check($sformatf("v%0d_wdata", i),  wd,        vt[i].wd);
            check($sformatf("v%0d_waddr", i),  32'(wa),   (vt[i].nwe != 0) ? 32'(vt[i].addr) : 32'd0);
            check($sformatf("v%0d_illegal", i), 32'(ill), 32'(vt[i].ill));
            check($sformatf("v%0d_rd_we", i),  32'(rdwe), 32'(vt[i].rdwe));
            check($sformatf("v%0d_rd_wdata", i), rdw,     vt[i].rdw);
            check($sformatf("v%0d_rd_idx", i), 32'(rdidx), 32'(vt[i].rd));
            check($sformatf("v%0d_retire", i), 32'(ret),  32'(vt[i].ret));
            check($sformatf("v%0d_csr", i),    csr_mem[vt[i].addr], vt[i].fin);
        end

        // Flush in RD, CAP, WR and DONE
        for (int fa = 1; fa <= 4; fa++) begin
            preload(12'h340, 32'h5);
            run_op(3'b001, 12'h340, 5'd1, 32'hAA, 5'd5, fa,
                   cyc, nwe, wd, wa, ill, rdwe, rdw, rdidx, ret);
            check($sformatf("flush%0d_cyc", fa), 32'(cyc), (fa <= 2) ? 32'd0 : 32'd4);
            check($sformatf("flush%0d_nwe", fa), 32'(nwe), (fa <= 2) ? 32'd0 : 32'd1);
            check($sformatf("flush%0d_csr", fa), csr_mem[12'h340], (fa <= 2) ? 32'h5 : 32'hAA);
            if (fa > 2) check($sformatf("flush%0d_retire", fa), 32'(ret), 32'd1);
            if (fa <= 2) check($sformatf("flush%0d_ready", fa), 32'(req_ready_o), 32'd1);
        end

        // Flush in IDLE blocks acceptance
        begin
            int seen;
            seen = 0;
            @(negedge clk);
            funct3_i = 3'b001; csr_addr_i = 12'h340; rs1_idx_i = 5'd1; rs1_data_i = 32'h1234;
            rd_idx_i = 5'd1; req_valid_i = 1'b1; flush_i = 1'b1;
            @(posedge clk); #1;
            req_valid_i = 1'b0; flush_i = 1'b0;
            @(negedge clk);
            check("idle_flush_ready", 32'(req_ready_o), 32'd1);
            repeat (5) begin
                if (done_o || csr_we_o) seen++;
                @(negedge clk);
            end
            check("idle_flush_noop", 32'(seen), 32'd0);
            check("idle_flush_csr", csr_mem[12'h340], 32'hAA);
        end

        // Reset asserted while the write is on the port
        preload(12'h341, 32'h33);
        @(negedge clk);
        funct3_i = 3'b001; csr_addr_i = 12'h341; rs1_idx_i = 5'd2; rs1_data_i = 32'h44;
        rd_idx_i = 5'd2; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstwr_we_before", 32'(csr_we_o), 32'd1);
        rst = 1'b1;
        #1;
        check("rstwr_we_after",  32'(csr_we_o),    32'd0);
        check("rstwr_ready",     32'(req_ready_o), 32'd0);
        @(posedge clk); #1;
        check("rstwr_csr", csr_mem[12'h341], 32'h33);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstwr_ready_after", 32'(req_ready_o), 32'd1);

        // Back-to-back: second request held valid is taken only once IDLE returns
        begin
            int d1, d2, early;
            logic [31:0] r1, r2;
            d1 = 0; d2 = 0; early = 0; r1 = '0; r2 = '0;
            preload(12'h340, 32'h11);
            @(negedge clk);
            funct3_i = 3'b001; csr_addr_i = 12'h340; rs1_idx_i = 5'd1; rs1_data_i = 32'h1;
            rd_idx_i = 5'd5; req_valid_i = 1'b1;
            @(posedge clk); #1;
            rs1_data_i = 32'h2; rd_idx_i = 5'd6;
            for (int n = 1; n <= 12; n++) begin
                if (n == 6) req_valid_i = 1'b0;
                @(negedge clk);
                if (n <= 4 && req_ready_o) early++;
                if (done_o) begin
                    if (d1 == 0) begin d1 = n; r1 = rd_wdata_o; end
                    else if (d2 == 0) begin d2 = n; r2 = rd_wdata_o; end
                end
                @(posedge clk); #1;
            end
            check("b2b_busy_ready", 32'(early), 32'd0);
            check("b2b_done1", 32'(d1), 32'd4);
            check("b2b_done2", 32'(d2), 32'd9);
            check("b2b_rdw1",  r1, 32'h11);
            check("b2b_rdw2",  r2, 32'h1);
            check("b2b_csr",   csr_mem[12'h340], 32'h2);
        end

        // Random operations against a reference model
        begin
            int r0, legal_cnt;
            logic [11:0] al [5];
            al[0] = 12'h340; al[1] = 12'h341; al[2] = 12'h300; al[3] = 12'hC00; al[4] = 12'hC01;
            legal_cnt = 0;
            @(negedge clk); #1;
            r0 = retire_cnt;
            for (int k = 0; k < 100; k++) begin
                logic [2:0] f3; logic [11:0] a; logic [4:0] ri, rdi; logic [31:0] d, init, op, nv;
                logic wr, eill;
                f3 = 3'($urandom_range(0, 7)); a = al[$urandom_range(0, 4)];
                ri = 5'($urandom_range(0, 3)); d = $urandom; rdi = 5'($urandom_range(0, 3));
                init = $urandom;
                wr   = (f3[1:0] == 2'b01) || (ri != 5'd0);
                eill = (f3[1:0] == 2'b00) || (wr && a[11:10] == 2'b11);
                op   = f3[2] ? {27'b0, ri} : d;
                nv   = (f3[1:0] == 2'b01) ? op : (f3[1:0] == 2'b10) ? (init | op) : (init & ~op);
                if (!eill) legal_cnt++;
                preload(a, init);
                run_op(f3, a, ri, d, rdi, 0, cyc, nwe, wd, wa, ill, rdwe, rdw, rdidx, ret);
                check($sformatf("rnd%0d_cyc", k), 32'(cyc), eill ? 32'd1 : (wr ? 32'd4 : 32'd3));
                check($sformatf("rnd%0d_rdw", k), rdw, eill ? 32'd0 : init);
                check($sformatf("rnd%0d_csr", k), csr_mem[a], (!eill && wr) ? nv : init);
            end
            @(negedge clk); #1;
            check("rnd_retire_count", 32'(retire_cnt - r0), 32'(legal_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
